// File: rtl/muskoka_pkg.sv
// Shared types and constants for the muskoka instruction-memory responder.
// Holds the FSM state encoding, bus widths and the wait-counter width.
package muskoka_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_SEL_W   = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/muskoka_ram_1rw.sv
// Single-port synchronous RAM with byte-lane write enables.
// A read on a write cycle returns the word as it was before the write.
module muskoka_ram_1rw
  import muskoka_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [WB_SEL_W-1:0]   we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WB_DATA_W-1:0]  dat_i,
  output logic [WB_DATA_W-1:0]  dat_o
);

  logic [WB_DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [WB_DATA_W-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rd_q <= mem[addr_i];
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (we_i[b]) begin
          mem[addr_i][8*b +: 8] <= dat_i[8*b +: 8];
        end
      end
    end
  end

  assign dat_o = rd_q;

endmodule

// File: rtl/muskoka_imem_responder.sv
// Wishbone B3 classic responder in front of an on-chip RAM: FSM, address
// decode, wait-state counter and output registers.
module muskoka_imem_responder
  import muskoka_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 busy_o
);

  localparam int AW = DEPTH_LOG2 + 2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic [WB_DATA_W-1:0]  dat_q, dat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic                  req;
  logic                  adr_ok;
  logic                  ram_go;
  logic                  ram_en;
  logic [WB_DATA_W-1:0]  ram_rdata;

  assign req = wb_cyc_i & wb_stb_i;
  // BASE_ADDR is aligned to the window size, so comparing the bits above the
  // window is an exact range check.
  assign adr_ok = (wb_adr_i[1:0] == 2'b00) && ((wb_adr_i >> AW) == (BASE_ADDR >> AW));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    ram_go  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d = wb_adr_i[AW-1:2];
          we_d  = wb_we_i;
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          if (!adr_ok) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            ram_go  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
          ram_go  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK, ST_ERR: state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  assign ack_d  = (state_d == ST_ACK);
  assign err_d  = (state_d == ST_ERR);
  assign busy_d = (state_d != ST_IDLE);

  // The RAM access happens on the edge entering ACK; gate with reset so a
  // request held during reset can never reach the array.
  assign ram_en = ram_go & rst_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  muskoka_ram_1rw #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i (clk_i),
    .en_i  (ram_en),
    .we_i  (sel_d & {WB_SEL_W{we_d}}),
    .addr_i(idx_d),
    .dat_i (dat_d),
    .dat_o (ram_rdata)
  );

  assign wb_dat_o = ack_q ? ram_rdata : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign busy_o   = busy_q;

endmodule
